// File: rtl/manchester_frame_tx_if.sv
// Byte-stream handshake feeding the Manchester frame transmitter.
// The source drives data/valid/last; the transmitter returns ready.
interface manchester_frame_tx_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       s_ready;

  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: preamble, SFD, payload, inter-frame gap, emitted as
// SER_WIDTH-bit OSERDESE2 words. Define MANCH_TX_CRC8_EN to append a CRC-8 byte.
module manchester_frame_tx #(
  parameter int unsigned SER_WIDTH      = 8,
  parameter int unsigned PREAMBLE_BYTES = 2,
  parameter logic [7:0]  SFD            = 8'hD5,
  parameter int unsigned MAX_LEN        = 64,
  parameter int unsigned IFG_WORDS      = 4
) (
  input  logic                 clk_div,
  input  logic                 rst,
  manchester_frame_tx_if.slave s_if,
  output logic [SER_WIDTH-1:0] ser_data,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err_underrun,
  output logic                 err_len
);
  localparam int unsigned WPB      = 16 / SER_WIDTH;
  localparam logic [7:0]  WPB_LAST = 8'(WPB - 1);
  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
  localparam logic [7:0]  LEN_MAX  = 8'(MAX_LEN);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
`ifdef MANCH_TX_CRC8_EN
    ST_CRC,
`endif
    ST_GAP
  } state_t;

  function automatic logic [15:0] manch(input logic [7:0] b);
    logic [15:0] w;
    w = '0;
    for (int unsigned i = 0; i < 8; i++) w[2*i +: 2] = {~b[i], b[i]};
    return w;
  endfunction

`ifdef MANCH_TX_CRC8_EN
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int unsigned i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  logic [7:0] crc_q, crc_d;
`endif

  state_t                 st_q, st_d;
  logic [7:0]             wcnt_q, wcnt_d;
  logic [7:0]             bcnt_q, bcnt_d;
  logic [15:0]            enc_q, enc_d;
  logic                   last_q, last_d;
  logic                   trunc_q, trunc_d;
  logic [SER_WIDTH-1:0]   ser_q, ser_d;
  logic                   busy_q, busy_d;
  logic                   fd_q, fd_d;
  logic                   eu_q, eu_d;
  logic                   el_q, el_d;
  logic                   last_word;

  // State and counters describe the word currently on ser_data; the handshake
  // point is the final word of the SFD or of a non-final payload byte.
  assign last_word      = (wcnt_q == WPB_LAST);
  assign s_if.s_ready   = !rst && last_word &&
                          ((st_q == ST_SFD) || ((st_q == ST_PAYLOAD) && !last_q));
  assign ser_data       = ser_q;
  assign busy           = busy_q;
  assign frame_done     = fd_q;
  assign err_underrun   = eu_q;
  assign err_len        = el_q;

  always_comb begin
    st_d    = st_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    enc_d   = enc_q;
    last_d  = last_q;
    trunc_d = trunc_q;
    eu_d    = 1'b0;
    el_d    = 1'b0;
`ifdef MANCH_TX_CRC8_EN
    crc_d   = crc_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (s_if.s_valid) begin
          st_d    = ST_PREAMBLE;
          wcnt_d  = '0;
          bcnt_d  = '0;
          enc_d   = manch(8'hAA);
          last_d  = 1'b0;
          trunc_d = 1'b0;
`ifdef MANCH_TX_CRC8_EN
          crc_d   = '0;
`endif
        end
      end
      ST_PREAMBLE: begin
        if (!last_word) begin
          wcnt_d = wcnt_q + 8'd1;
          enc_d  = enc_q << SER_WIDTH;
        end else begin
          wcnt_d = '0;
          if (bcnt_q == PRE_LAST) begin
            st_d   = ST_SFD;
            bcnt_d = '0;
            enc_d  = manch(SFD);
          end else begin
            bcnt_d = bcnt_q + 8'd1;
            enc_d  = manch(8'hAA);
          end
        end
      end
      ST_SFD, ST_PAYLOAD: begin
        if (!last_word) begin
          wcnt_d = wcnt_q + 8'd1;
          enc_d  = enc_q << SER_WIDTH;
        end else if ((st_q == ST_PAYLOAD) && last_q) begin
          wcnt_d = '0;
`ifdef MANCH_TX_CRC8_EN
          st_d   = ST_CRC;
          enc_d  = manch(crc_q);
`else
          st_d   = ST_GAP;
`endif
        end else if (s_if.s_valid) begin
          st_d   = ST_PAYLOAD;
          wcnt_d = '0;
          bcnt_d = bcnt_q + 8'd1;
          enc_d  = manch(s_if.s_data);
`ifdef MANCH_TX_CRC8_EN
          crc_d  = crc8(crc_q, s_if.s_data);
`endif
          if (s_if.s_last) begin
            last_d = 1'b1;
          end else if ((bcnt_q + 8'd1) == LEN_MAX) begin
            last_d  = 1'b1;
            trunc_d = 1'b1;
            el_d    = 1'b1;
          end
        end else begin
          st_d   = ST_GAP;
          wcnt_d = '0;
          eu_d   = 1'b1;
        end
      end
`ifdef MANCH_TX_CRC8_EN
      ST_CRC: begin
        if (!last_word) begin
          wcnt_d = wcnt_q + 8'd1;
          enc_d  = enc_q << SER_WIDTH;
        end else begin
          st_d   = ST_GAP;
          wcnt_d = '0;
        end
      end
`endif
      ST_GAP: begin
        if (wcnt_q == IFG_LAST) begin
          st_d   = ST_IDLE;
          wcnt_d = '0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: st_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    ser_d = '0;
    if ((st_d != ST_IDLE) && (st_d != ST_GAP)) ser_d = enc_d[15 -: SER_WIDTH];
    busy_d = (st_d != ST_IDLE);
`ifdef MANCH_TX_CRC8_EN
    fd_d = (st_d == ST_CRC) && (wcnt_d == WPB_LAST) && !trunc_d;
`else
    fd_d = (st_d == ST_PAYLOAD) && last_d && (wcnt_d == WPB_LAST) && !trunc_d;
`endif
  end

  always_ff @(posedge clk_div) begin
    if (rst) begin
      st_q    <= ST_IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      enc_q   <= '0;
      last_q  <= 1'b0;
      trunc_q <= 1'b0;
      ser_q   <= '0;
      busy_q  <= 1'b0;
      fd_q    <= 1'b0;
      eu_q    <= 1'b0;
      el_q    <= 1'b0;
`ifdef MANCH_TX_CRC8_EN
      crc_q   <= '0;
`endif
    end else begin
      st_q    <= st_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      enc_q   <= enc_d;
      last_q  <= last_d;
      trunc_q <= trunc_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      fd_q    <= fd_d;
      eu_q    <= eu_d;
      el_q    <= el_d;
`ifdef MANCH_TX_CRC8_EN
      crc_q   <= crc_d;
`endif
    end
  end
endmodule

// File: tb/tb_manchester_frame_tx.sv
// Self-checking bench for manchester_frame_tx: byte streams are turned into an
// expected per-cycle word/flag sequence by a frame-level reference model.
`timescale 1ns/1ps
module tb_manchester_frame_tx;
  localparam int         SW    = 8;
  localparam int         PB    = 2;
  localparam logic [7:0] SFD_B = 8'hD5;
  localparam int         MAXL  = 5;
  localparam int         IFG   = 4;
  localparam int         WPB   = 16 / SW;

  typedef struct packed {
    logic [SW-1:0] ser;
    logic          busy;
    logic          rdy;
    logic          fd;
    logic          eu;
    logic          el;
  } obs_t;

  typedef logic [8:0] stream_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] ser_data;
  logic          busy, frame_done, err_underrun, err_len;
  int            tests = 0;
  int            fails = 0;
  obs_t          exp_q[$];

  manchester_frame_tx_if sif();

  manchester_frame_tx #(
    .SER_WIDTH(SW), .PREAMBLE_BYTES(PB), .SFD(SFD_B), .MAX_LEN(MAXL), .IFG_WORDS(IFG)
  ) dut (
    .clk_div(clk), .rst(rst), .s_if(sif), .ser_data(ser_data), .busy(busy),
    .frame_done(frame_done), .err_underrun(err_underrun), .err_len(err_len)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.ser  = ser_data;
    o.busy = busy;
    o.rdy  = sif.s_ready;
    o.fd   = frame_done;
    o.eu   = err_underrun;
    o.el   = err_len;
    return o;
  endfunction

  // Reference encoding: each bit, MSB first, appends "10" for 0 and "01" for 1.
  function automatic logic [15:0] manch_ref(input logic [7:0] b);
    logic [15:0] e;
    e = '0;
    for (int i = 7; i >= 0; i--) e = (e << 2) | (b[i] ? 16'd1 : 16'd2);
    return e;
  endfunction

  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic       fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[7] ^ d[i];
      r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return r;
  endfunction

  function automatic void push_word(input logic [SW-1:0] s, input logic b, input logic r,
                                    input logic f, input logic u, input logic l);
    obs_t o;
    o.ser = s; o.busy = b; o.rdy = r; o.fd = f; o.eu = u; o.el = l;
    exp_q.push_back(o);
  endfunction

  function automatic void push_byte(input logic [7:0] b, input logic rdy_end, input logic el_first);
    logic [15:0] e;
    e = manch_ref(b);
    for (int k = 0; k < WPB; k++)
      push_word(SW'(e >> (16 - SW * (k + 1))), 1'b1, rdy_end && (k == WPB - 1), 1'b0, 1'b0,
                el_first && (k == 0));
  endfunction

  function automatic void build_expected(input stream_t str);
    int   pos;
    int   k;
    bit   ended, aborted, trunc;
    logic [7:0] crc;
    obs_t t;
    pos = 0;
    exp_q.delete();
    while (pos < str.size()) begin
      k = 0; ended = 0; aborted = 0; trunc = 0; crc = 8'h00;
      for (int b = 0; b < PB; b++) push_byte(8'hAA, 1'b0, 1'b0);
      push_byte(SFD_B, 1'b1, 1'b0);
      while (!ended) begin
        if (pos >= str.size()) begin
          aborted = 1; ended = 1;
        end else begin
          k++;
          crc   = crc_ref(crc, str[pos][7:0]);
          trunc = !str[pos][8] && (k == MAXL);
          ended = str[pos][8] || trunc;
          push_byte(str[pos][7:0], !ended, trunc);
          pos++;
        end
      end
`ifdef MANCH_TX_CRC8_EN
      if (!aborted) push_byte(crc, 1'b0, 1'b0);
`endif
      if (!aborted && !trunc) begin
        t = exp_q[exp_q.size() - 1];
        t.fd = 1'b1;
        exp_q[exp_q.size() - 1] = t;
      end
      for (int g = 0; g < IFG; g++) push_word('0, 1'b1, 1'b0, 1'b0, aborted && (g == 0), 1'b0);
      push_word('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) push_word('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic drive_src(input stream_t str, input int idx);
    if (idx < str.size()) begin
      sif.s_valid = 1'b1;
      sif.s_data  = str[idx][7:0];
      sif.s_last  = str[idx][8];
    end else begin
      sif.s_valid = 1'b0;
      sif.s_data  = 8'($urandom);
      sif.s_last  = 1'b0;
    end
  endtask

  // Drives the stream with an always-ready source and checks every cycle against exp_q.
  task automatic run_stream(input stream_t str, input string tag);
    int   idx;
    bit   hs;
    obs_t got;
    idx = 0;
    drive_src(str, idx);
    for (int t = 0; t < exp_q.size(); t++) begin
      hs = sif.s_valid && sif.s_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      drive_src(str, idx);
      got = observe();
      tests++;
      if (got !== exp_q[t]) begin
        fails++;
        $display("FAIL %s word %0d: got ser=%h busy=%b rdy=%b fd=%b eu=%b el=%b, expected ser=%h busy=%b rdy=%b fd=%b eu=%b el=%b",
                 tag, t, got.ser, got.busy, got.rdy, got.fd, got.eu, got.el,
                 exp_q[t].ser, exp_q[t].busy, exp_q[t].rdy, exp_q[t].fd, exp_q[t].eu, exp_q[t].el);
      end
    end
    tests++;
    if (idx !== str.size()) begin
      fails++;
      $display("FAIL %s consumed: got %0d bytes, expected %0d", tag, idx, str.size());
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst = 1'b1;
    sif.s_valid = 1'b1; sif.s_data = 8'($urandom); sif.s_last = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      got = observe();
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL reset_hold: got %h, expected 0", got);
      end
    end
    rst = 1'b0;
    sif.s_valid = 1'b0;
    @(posedge clk); #1;
    got = observe();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL reset_release: got %h, expected 0", got);
    end
  endtask

  task automatic test_known_frame();
    stream_t s;
    logic [SW-1:0] w[$];
    s.push_back(9'h101);
    exp_q.delete();
    w.push_back(8'h66); w.push_back(8'h66); w.push_back(8'h66); w.push_back(8'h66);
    w.push_back(8'h59); w.push_back(8'h99); w.push_back(8'hAA); w.push_back(8'hA9);
`ifdef MANCH_TX_CRC8_EN
    w.push_back(8'hAA); w.push_back(8'h95);
`endif
    for (int i = 0; i < w.size(); i++)
      push_word(w[i], 1'b1, (i == 5), (i == w.size() - 1), 1'b0, 1'b0);
    for (int g = 0; g < 4; g++) push_word('0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push_word('0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_stream(s, "known_frame");
  endtask

  task automatic test_underrun();
    stream_t s;
    s.push_back({1'b0, 8'($urandom)});
    s.push_back({1'b0, 8'($urandom)});
    build_expected(s);
    run_stream(s, "underrun");
  endtask

  task automatic test_len_limit();
    stream_t s;
    for (int i = 0; i < MAXL + 2; i++) s.push_back({1'b0, 8'($urandom)});
    build_expected(s);
    run_stream(s, "len_truncate");
    s.delete();
    for (int i = 0; i < MAXL; i++) s.push_back({(i == MAXL - 1), 8'($urandom)});
    build_expected(s);
    run_stream(s, "len_exact_last");
  endtask

  task automatic test_back_to_back();
    stream_t s;
    s.push_back({1'b0, 8'h00});
    s.push_back({1'b1, 8'hFF});
    s.push_back({1'b1, 8'h5A});
    s.push_back({1'b1, 8'hC3});
    build_expected(s);
    run_stream(s, "back_to_back");
  endtask

  task automatic test_reset_midframe();
    stream_t s;
    int      idx;
    bit      hs;
    obs_t    got;
    s.push_back({1'b0, 8'h3C});
    s.push_back({1'b0, 8'h81});
    s.push_back({1'b1, 8'h7E});
    idx = 0;
    drive_src(s, idx);
    repeat ((PB + 2) * WPB) begin
      hs = sif.s_valid && sif.s_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      drive_src(s, idx);
    end
    tests++;
    if (busy !== 1'b1 || sif.s_ready !== 1'b1) begin
      fails++;
      $display("FAIL midframe_pre: got busy=%b rdy=%b, expected busy=1 rdy=1", busy, sif.s_ready);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (sif.s_ready !== 1'b0) begin
      fails++;
      $display("FAIL midframe_rdy_in_rst: got %b, expected 0", sif.s_ready);
    end
    @(posedge clk); #1;
    got = observe();
    tests++;
    if (got !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got %h, expected 0", got);
    end
    rst = 1'b0;
    sif.s_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      got = observe();
      tests++;
      if (got !== '0) begin
        fails++;
        $display("FAIL midframe_after: got %h, expected 0", got);
      end
    end
  endtask

  task automatic test_random();
    stream_t s;
    int      len;
    for (int n = 0; n < 25; n++) begin
      s.delete();
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        if (i == len - 1) s.push_back({1'($urandom_range(0, 1)), 8'($urandom)});
        else              s.push_back({($urandom_range(0, 4) == 0), 8'($urandom)});
      end
      build_expected(s);
      run_stream(s, $sformatf("random%0d", n));
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    sif.s_last  = 1'b0;
    test_reset();
    test_known_frame();
    test_underrun();
    test_len_limit();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/manchester_frame_tx.md
MANCHESTER_FRAME_TX -- requirements
Module: manchester_frame_tx

Interface
REQ-001 Parameter SER_WIDTH, default 8, width of the serializer word; legal values 4, 8, 16.
REQ-002 Parameter PREAMBLE_BYTES, default 2, count of 0xAA preamble bytes; legal range 1..15.
REQ-003 Parameter SFD, default 8'hD5, start-of-frame delimiter byte.
REQ-004 Parameter MAX_LEN, default 64, maximum payload bytes per frame; legal range 1..255.
REQ-005 Parameter IFG_WORDS, default 4, idle words after every frame; legal range 1..255.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk_div  input  1  word clock feeding the OSERDESE2 CLKDIV domain; all logic on its rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 s_data  input  8  payload byte.
REQ-010 s_valid  input  1  s_data valid.
REQ-011 s_last  input  1  s_data is the final byte of the frame.
REQ-012 s_ready  output  1  byte accepted this cycle when s_valid and s_ready are both high.
REQ-013 ser_data  output  SER_WIDTH  Manchester word, MSB first on line, wired to OSERDESE2 D1 (MSB) .. Dn (LSB).
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 frame_done  output  1  one-cycle pulse on the last word of a normally terminated frame.
REQ-016 err_underrun  output  1  one-cycle pulse when a frame is aborted for lack of data.
REQ-017 err_len  output  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Function
REQ-018 Encoding: each bit b SHALL become the pair {~b, b} (0 -> "10", 1 -> "01"); bytes go MSB first; a byte occupies WPB = 16/SER_WIDTH consecutive words.
REQ-019 ser_data, busy and all pulse outputs SHALL be registered; s_ready SHALL be combinational from state and counters only, never from s_valid.
REQ-020 States: IDLE, PREAMBLE, SFD, PAYLOAD, CRC (MANCH_TX_CRC8_EN only), GAP.
REQ-021 IDLE: ser_data = 0; s_valid high moves to PREAMBLE and the next ser_data word is the first preamble word; no byte is consumed.
REQ-022 PREAMBLE emits PREAMBLE_BYTES*WPB words of encoded 0xAA, then SFD emits WPB words of encoded SFD.
REQ-023 s_ready SHALL be high only on the last word of the SFD byte and on the last word of each non-final PAYLOAD byte; the accepted byte is emitted starting the next cycle, with no gap.
REQ-024 If s_valid is low when s_ready is high, the frame SHALL abort: err_underrun pulses, state moves to GAP, ser_data = 0 from the next cycle.
REQ-025 A byte accepted with s_last high ends the payload; then CRC (if compiled) or GAP follows with no gap; frame_done pulses on the final non-idle word.
REQ-026 A payload byte counter SHALL count accepted bytes; when byte MAX_LEN is accepted without s_last, it is treated as last, err_len pulses with acceptance, and frame_done does not pulse.
REQ-027 GAP emits IFG_WORDS words of 0, then enters IDLE; s_ready stays low in GAP and IDLE.
REQ-028 A byte with s_valid high during GAP SHALL be held by the source and starts the next frame from IDLE.

Reset
REQ-029 On rst high, state SHALL be IDLE and ser_data, busy, frame_done, err_underrun, err_len SHALL be 0 on the following cycle; s_ready SHALL be 0 while rst is high.
REQ-030 Reset mid-frame SHALL drop the frame immediately with no error pulse; the CRC register and all counters clear.

Configuration
REQ-031 Macro MANCH_TX_CRC8_EN defined: CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR) over payload bytes is appended as one encoded byte after the last payload byte; aborted frames emit no CRC.
REQ-032 Macro MANCH_TX_CRC8_EN undefined: no CRC state or logic; GAP follows the last payload byte directly.

Verification
REQ-033 SER_WIDTH=8, payload {0x01, last} -> ser_data 0x66,0x66,0x66,0x66,0x59,0x99,0xAA,0xA9, then 4 words of 0x00; frame_done with 0xA9.
REQ-034 Same with MANCH_TX_CRC8_EN -> 0xAA,0x95 (CRC 0x07) follow 0xA9; frame_done with 0x95.
REQ-035 3-byte frame, s_valid dropped before byte 2 -> err_underrun pulse, no CRC, ser_data 0 for IFG_WORDS words, busy low after.
REQ-036 MAX_LEN=4, 6 bytes without s_last -> 4 bytes sent, err_len pulse on byte 4, bytes 5-6 start next frame after GAP.
REQ-037 SER_WIDTH=4 and 16 -> preamble words 0x6 and 0x6666; s_ready high once every 4 and every 1 cycles in PAYLOAD.
REQ-038 rst asserted during payload -> next cycle ser_data 0, busy 0, s_ready 0, no pulses.
